// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer: FSM state encoding
// and the counter-width calculation.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILISE = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } seq_state_e;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Bits needed to count 0 .. max_cycles-1; never narrower than one bit.
   function automatic int cnt_width(input int max_cycles);
      return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync.sv
// Two-flop synchroniser for a single asynchronous flag, with synchronous
// active-high clear. Output latency is two clock cycles.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock with
// retries, qualifies lock, then releases the downstream domain reset.
// Optional macro PLL_SEQ_AUTO_RECOVER_EN: FAULT times out and restarts.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES  = 65536,
   parameter int LOCK_STABLE_CYCLES   = 1024,
   parameter int RELEASE_DELAY_CYCLES = 8,
   parameter int MAX_RETRIES          = 3,
   parameter int RETRY_W              = 2
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               dom_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               lock_lost
);

   localparam int CNT_W = cnt_width(max4(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES, RELEASE_DELAY_CYCLES));

   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   logic locked_s;

   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               pll_rst_q, pll_rst_d;
   logic               dom_rst_q, dom_rst_d;
   logic               ready_q, ready_d;
   logic               fault_q, fault_d;
   logic               lock_lost_q, lock_lost_d;

   sync_2ff u_lock_sync (
      .clk_i   (refclk),
      .rst_i   (rst),
      .async_i (pll_locked),
      .sync_o  (locked_s)
   );

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         dom_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         dom_rst_q   <= dom_rst_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d     = state_q;
      retry_d     = retry_q;
      lock_lost_d = 1'b0;

      unique case (state_q)
         RESET_PLL: begin
            if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // Lock beats a coincident timeout.
            if (locked_s) begin
               state_d = STABILISE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = FAULT;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = RESET_PLL;
               end
            end
         end
         STABILISE: begin
            if (!locked_s)                 state_d = WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = RELEASE;
         end
         RELEASE: begin
            if (!locked_s) begin
               state_d     = RESET_PLL;
               lock_lost_d = 1'b1;
            end else if (cnt_q == RELEASE_LAST) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d     = RESET_PLL;
               lock_lost_d = 1'b1;
            end
         end
         FAULT: begin
`ifdef PLL_SEQ_AUTO_RECOVER_EN
            if (cnt_q == TIMEOUT_LAST) begin
               state_d = RESET_PLL;
               retry_d = '0;
            end
`else
            state_d = FAULT;
`endif
         end
         default: state_d = RESET_PLL;
      endcase

      // Counter restarts on every state entry; in RUN or sticky FAULT it free-runs unobserved.
      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

      // Moore outputs decoded from the next state so they are valid in the state's first cycle.
      pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
      dom_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   assign pll_rst   = pll_rst_q;
   assign dom_rst   = dom_rst_q;
   assign ready     = ready_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus
// randomised lock patterns compared against a phase/elapsed-time model.
module tb_pll_lock_sequencer;

   localparam int RST_HOLD  = 4;
   localparam int TIMEOUT   = 32;
   localparam int STABLE    = 8;
   localparam int REL_DELAY = 2;
   localparam int RETRIES   = 2;

   // Model phases (independent of the RTL encoding).
   localparam int M_HOLD  = 10;
   localparam int M_WAIT  = 20;
   localparam int M_STAB  = 30;
   localparam int M_REL   = 40;
   localparam int M_RUN   = 50;
   localparam int M_FAULT = 60;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, dom_rst, ready, fault, lock_lost;
   logic [1:0] retry_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit lost_seen = 1'b0;

   int m_phase = M_HOLD;
   int m_elapsed = 0;
   int m_retries = 0;
   bit m_lost = 1'b0;
   bit m_s1 = 1'b0;
   bit m_s2 = 1'b0;

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES      (RST_HOLD),
      .LOCK_TIMEOUT_CYCLES  (TIMEOUT),
      .LOCK_STABLE_CYCLES   (STABLE),
      .RELEASE_DELAY_CYCLES (REL_DELAY),
      .MAX_RETRIES          (RETRIES),
      .RETRY_W              (2)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .dom_rst    (dom_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .lock_lost  (lock_lost)
   );

   always #5 refclk = ~refclk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the reference by one clock edge given inputs sampled at that edge.
   task automatic model_edge(input bit r, input bit l);
      bit ls;
      int done;
      int nxt;
      ls = m_s2;
      if (r) begin
         m_phase = M_HOLD; m_elapsed = 0; m_retries = 0; m_lost = 1'b0;
         m_s1 = 1'b0; m_s2 = 1'b0;
         return;
      end
      m_lost = 1'b0;
      done = m_elapsed + 1;
      nxt = m_phase;
      case (m_phase)
         M_HOLD: if (done >= RST_HOLD) nxt = M_WAIT;
         M_WAIT: begin
            if (ls) nxt = M_STAB;
            else if (done >= TIMEOUT) begin
               if (m_retries >= RETRIES) nxt = M_FAULT;
               else begin m_retries++; nxt = M_HOLD; end
            end
         end
         M_STAB: begin
            if (!ls) nxt = M_WAIT;
            else if (done >= STABLE) nxt = M_REL;
         end
         M_REL: begin
            if (!ls) begin nxt = M_HOLD; m_lost = 1'b1; end
            else if (done >= REL_DELAY) begin nxt = M_RUN; m_retries = 0; end
         end
         M_RUN: if (!ls) begin nxt = M_HOLD; m_lost = 1'b1; end
         default: begin
`ifdef PLL_SEQ_AUTO_RECOVER_EN
            if (done >= TIMEOUT) begin nxt = M_HOLD; m_retries = 0; end
`endif
         end
      endcase
      m_elapsed = (nxt != m_phase) ? 0 : done;
      m_phase = nxt;
      m_s2 = m_s1;
      m_s1 = l;
   endtask

   task automatic compare_all();
      check("pll_rst",   pll_rst,   (m_phase == M_HOLD) || (m_phase == M_FAULT));
      check("dom_rst",   dom_rst,   m_phase != M_RUN);
      check("ready",     ready,     m_phase == M_RUN);
      check("fault",     fault,     m_phase == M_FAULT);
      check("retry_cnt", retry_cnt, m_retries);
      check("lock_lost", lock_lost, m_lost);
   endtask

   task automatic tick();
      bit r;
      bit l;
      r = rst;
      l = pll_locked;
      @(posedge refclk);
      model_edge(r, l);
      cyc++;
      #1;
      lost_seen = lost_seen | lock_lost;
      compare_all();
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
      lost_seen = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int budget);
      int n;
      n = 0;
      while (!ready && n < budget) begin
         tick();
         n++;
      end
      check(tag, ready, 1'b1);
   endtask

   initial begin
      // Happy path: locked throughout.
      pll_locked = 1'b1;
      do_reset();
      check("rst_pll_rst",   pll_rst,   1'b1);
      check("rst_dom_rst",   dom_rst,   1'b1);
      check("rst_ready",     ready,     1'b0);
      check("rst_retry",     retry_cnt, 2'd0);
      run_to(3);
      check("hp_pll_rst_c3", pll_rst, 1'b1);
      run_to(4);
      check("hp_pll_rst_c4", pll_rst, 1'b0);
      run_to(14);
      check("hp_ready_c14",  ready,   1'b0);
      check("hp_domrst_c14", dom_rst, 1'b1);
      run_to(15);
      check("hp_ready_c15",  ready,     1'b1);
      check("hp_domrst_c15", dom_rst,   1'b0);
      check("hp_retry_c15",  retry_cnt, 2'd0);
      check("hp_fault_c15",  fault,     1'b0);

      // Loss of lock in RUN.
      run_to(20);
      pll_locked = 1'b0;
      tick();
      tick();
      check("loss_ready_still", ready, 1'b1);
      tick();
      check("loss_pulse",   lock_lost, 1'b1);
      check("loss_domrst",  dom_rst,   1'b1);
      check("loss_ready",   ready,     1'b0);
      check("loss_pll_rst", pll_rst,   1'b1);
      pll_locked = 1'b1;
      tick();
      check("loss_pulse_end", lock_lost, 1'b0);
      tick(); tick();
      check("loss_hold_c4", pll_rst, 1'b1);
      tick();
      check("loss_hold_end", pll_rst, 1'b0);
      wait_ready("loss_relock", 40);

      // Reset while in RUN.
      rst = 1'b1;
      tick();
      check("rstrun_ready",   ready,   1'b0);
      check("rstrun_pll_rst", pll_rst, 1'b1);
      check("rstrun_domrst",  dom_rst, 1'b1);
      rst = 1'b0;
      cyc = 0;
      run_to(15);
      check("rstrun_restart", ready, 1'b1);

      // Glitch during STABILISE at its 6th cycle.
      do_reset();
      run_to(10);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      run_to(23);
      check("glitch_ready_c23", ready, 1'b0);
      run_to(24);
      check("glitch_ready_c24", ready, 1'b1);
      check("glitch_no_lost",   lost_seen, 1'b0);

      // Never locks: three attempts, then FAULT.
      pll_locked = 1'b0;
      do_reset();
      run_to(35);
      check("nl_wait_c35",  pll_rst,   1'b0);
      run_to(36);
      check("nl_retry1",    retry_cnt, 2'd1);
      check("nl_pll_rst2",  pll_rst,   1'b1);
      run_to(72);
      check("nl_retry2",    retry_cnt, 2'd2);
      check("nl_pll_rst3",  pll_rst,   1'b1);
      run_to(107);
      check("nl_fault_c107", fault, 1'b0);
      run_to(108);
      check("nl_fault_c108", fault,     1'b1);
      check("nl_fault_rst",  pll_rst,   1'b1);
      check("nl_fault_retry", retry_cnt, 2'd2);
`ifdef PLL_SEQ_AUTO_RECOVER_EN
      run_to(139);
      check("ar_fault_c139", fault, 1'b1);
      run_to(140);
      check("ar_fault_c140", fault,     1'b0);
      check("ar_pll_rst",    pll_rst,   1'b1);
      check("ar_retry",      retry_cnt, 2'd0);
      pll_locked = 1'b1;
      wait_ready("ar_ready", 60);
      pll_locked = 1'b0;
      do_reset();
      run_to(108);
`else
      run_to(180);
      check("nl_sticky", fault, 1'b1);
`endif

      // Reset while in FAULT.
      rst = 1'b1;
      tick();
      check("rstf_fault",   fault,     1'b0);
      check("rstf_pll_rst", pll_rst,   1'b1);
      check("rstf_retry",   retry_cnt, 2'd0);
      rst = 1'b0;

      // Randomised lock patterns with occasional resets.
      for (int seg = 0; seg < 80; seg++) begin
         int len;
         len = $urandom_range(1, 60);
         pll_locked = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < len; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            tick();
         end
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
